vector_list_sequencer: RTL

- Frame-level initiator for the vector display line drawer. On each frame request it walks a vertex list in external memory and issues one line command per pen-down segment. It waits for completion of each line before issuing the next.
- Sits between the frame/vertex store and the line drawer. Drives the drawer's start/end coordinates and consumes its line_done.

---
 rtl/vector_list_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vector_list_sequencer.sv
// Frame-level initiator for the vector line drawer: walks the vertex list,
// issues one line command per visible pen-down segment and waits for each
// line to finish before fetching the next vertex.
module vector_list_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int COORD_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic                     mem_rd,
  input  logic [2*COORD_WIDTH+1:0] mem_data,
  output logic                     line_start,
  output logic [COORD_WIDTH-1:0]   x0,
  output logic [COORD_WIDTH-1:0]   y0,
  output logic [COORD_WIDTH-1:0]   x1,
  output logic [COORD_WIDTH-1:0]   y1,
  input  logic                     line_done,
  output logic                     beam_blank,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     frame_error,
  output logic [ADDR_WIDTH-1:0]    seg_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_LINE, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]  addr;
  logic [COORD_WIDTH-1:0] cx, cy;
  logic                   eol_q;
  logic [TW-1:0]          wait_cnt;

  logic                   v_eol, v_pen;
  logic [COORD_WIDTH-1:0] v_x, v_y;
  assign {v_eol, v_pen, v_x, v_y} = mem_data;

  logic addr_max, seg_draw, done_ok, timeout;
  assign addr_max = (addr == '1);
  // zero-length pen-down segments are dropped, not drawn
  assign seg_draw = v_pen && ((v_x != cx) || (v_y != cy));
  // first WAIT_LINE cycle may still see the previous line's done level
  assign done_ok  = line_done && (wait_cnt != '0);
  assign timeout  = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign mem_addr = addr;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (frame_start) state_nx = FETCH;
      FETCH:     state_nx = WAIT_MEM;
      WAIT_MEM: begin
        if (seg_draw)              state_nx = ISSUE;
        else if (v_eol || addr_max) state_nx = DONE;
        else                       state_nx = FETCH;
      end
      ISSUE:     state_nx = WAIT_LINE;
      WAIT_LINE: begin
        if (done_ok)      state_nx = (eol_q || addr_max) ? DONE : FETCH;
        else if (timeout) state_nx = DONE;
      end
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // state-decoded strobes and status
  always_comb begin
    mem_rd     = 1'b0;
    line_start = 1'b0;
    beam_blank = 1'b1;
    frame_busy = 1'b0;
    frame_done = 1'b0;
    case (state)
      FETCH:     begin mem_rd = 1'b1; frame_busy = 1'b1; end
      WAIT_MEM:  frame_busy = 1'b1;
      ISSUE:     begin line_start = 1'b1; beam_blank = 1'b0; frame_busy = 1'b1; end
      WAIT_LINE: begin beam_blank = 1'b0; frame_busy = 1'b1; end
      DONE:      frame_done = 1'b1;
      default:   ;
    endcase
  end

  // datapath: list address, beam position, line coordinates, status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      cx          <= '0;
      cy          <= '0;
      x0          <= '0;
      y0          <= '0;
      x1          <= '0;
      y1          <= '0;
      eol_q       <= 1'b0;
      wait_cnt    <= '0;
      seg_count   <= '0;
      frame_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          addr        <= '0;
          cx          <= '0;
          cy          <= '0;
          seg_count   <= '0;
          frame_error <= 1'b0;
        end
        WAIT_MEM: begin
          eol_q <= v_eol;
          if (seg_draw) begin
            x0 <= cx;
            y0 <= cy;
            x1 <= v_x;
            y1 <= v_y;
          end else begin
            if (!v_pen) begin
              cx <= v_x;
              cy <= v_y;
            end
            // addr never wraps: running off the end is an error
            if (!v_eol) begin
              if (addr_max) frame_error <= 1'b1;
              else          addr <= addr + 1'b1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (seg_count != '1) seg_count <= seg_count + 1'b1;
        end
        WAIT_LINE: begin
          if (done_ok) begin
            cx <= x1;
            cy <= y1;
            if (!eol_q) begin
              if (addr_max) frame_error <= 1'b1;
              else          addr <= addr + 1'b1;
            end
          end else if (timeout) begin
            frame_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
